// File: rtl/lc3_seq_ctrl.sv
// lc3_seq_ctrl - multi-cycle LC-3 subset sequencer.
//
// Walks fetch / decode / execute for ADD, AND, NOT, BR, JMP, JSR, LDR, STR
// and a software pause opcode. Every control output is decoded from the
// current state (plus IR_5 / IR_11 where noted), so the datapath sees the
// strobes in the same cycle the state is entered.
//
// Parameters
//   MEM_WAIT  : SRAM wait cycles before the capture cycle (0..15)
//   STEP_MODE : 1 = pause after every IR load, resume into DECODE
// Ports
//   Clk, Reset            : rising-edge clock, async active-high reset
//   Run, Continue         : start from HALTED, pause release handshake
//   Opcode, IR_5, IR_11   : instruction fields, BEN : branch enable
//   LD[7:0]               : MAR, MDR, IR, BEN, CC, REG, PC, LED load enables
//   GATE[3:0]             : PC, MDR, ALU, MARMUX bus gates
//   PCMUX, DRMUX, SR1MUX, SR2MUX, ADDR1MUX, ADDR2MUX, ALUK : datapath selects
//   Mem_OE, Mem_WE        : SRAM read / write strobes
//   Halted                : high only while HALTED
module lc3_seq_ctrl #(
    parameter int unsigned MEM_WAIT  = 2,
    parameter bit          STEP_MODE = 1'b0
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Run,
    input  logic       Continue,
    input  logic [3:0] Opcode,
    input  logic       IR_5,
    input  logic       IR_11,
    input  logic       BEN,
    output logic [7:0] LD,
    output logic [3:0] GATE,
    output logic [1:0] PCMUX,
    output logic       DRMUX,
    output logic       SR1MUX,
    output logic       SR2MUX,
    output logic       ADDR1MUX,
    output logic [1:0] ADDR2MUX,
    output logic [1:0] ALUK,
    output logic       Mem_OE,
    output logic       Mem_WE,
    output logic       Halted
);

    localparam int unsigned L_MAR = 7, L_MDR = 6, L_IR = 5, L_BEN = 4;
    localparam int unsigned L_CC  = 3, L_REG = 2, L_PC = 1, L_LED = 0;
    localparam int unsigned G_PC  = 3, G_MDR = 2, G_ALU = 1, G_MARMUX = 0;
    localparam logic [3:0]  WAIT_LAST = 4'(MEM_WAIT);

    // Reads have two return points (IR_LD, LDR_D), so each gets its own state.
    typedef enum logic [4:0] {
        S_HALTED, S_FETCH, S_FETCH_RD, S_IR_LD, S_DECODE,
        S_ADD, S_AND, S_NOT, S_BR, S_BR_T, S_JMP, S_JSR, S_JSR_T,
        S_LDR_A, S_LDR_RD, S_LDR_D, S_STR_A, S_STR_M, S_STR_WR,
        S_PAUSE1, S_PAUSE2
    } state_t;

    state_t     state_r;
    state_t     next_state_s;
    logic [3:0] wait_cnt_r;
    logic       mem_state_s;
    logic       mem_last_s;

    assign mem_state_s = (state_r == S_FETCH_RD) || (state_r == S_LDR_RD) ||
                         (state_r == S_STR_WR);
    assign mem_last_s  = (wait_cnt_r == WAIT_LAST);

    // State register and wait counter; the counter runs only while a memory
    // state repeats, so it is zero on every entry to a read or write.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_r    <= S_HALTED;
            wait_cnt_r <= 4'd0;
        end else begin
            state_r <= next_state_s;
            if (mem_state_s && (next_state_s == state_r)) begin
                wait_cnt_r <= wait_cnt_r + 4'd1;
            end else begin
                wait_cnt_r <= 4'd0;
            end
        end
    end

    // Next-state decode.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            S_HALTED:   next_state_s = Run ? S_FETCH : S_HALTED;
            S_FETCH:    next_state_s = S_FETCH_RD;
            S_FETCH_RD: next_state_s = mem_last_s ? S_IR_LD : S_FETCH_RD;
            S_IR_LD:    next_state_s = STEP_MODE ? S_PAUSE1 : S_DECODE;
            S_DECODE: begin
                case (Opcode)
                    4'b0001: next_state_s = S_ADD;
                    4'b0101: next_state_s = S_AND;
                    4'b1001: next_state_s = S_NOT;
                    4'b0000: next_state_s = S_BR;
                    4'b1100: next_state_s = S_JMP;
                    4'b0100: next_state_s = S_JSR;
                    4'b0110: next_state_s = S_LDR_A;
                    4'b0111: next_state_s = S_STR_A;
                    4'b1101: next_state_s = S_PAUSE1;
                    default: next_state_s = S_FETCH;
                endcase
            end
            S_ADD, S_AND, S_NOT: next_state_s = S_FETCH;
            S_BR:       next_state_s = BEN ? S_BR_T : S_FETCH;
            S_BR_T:     next_state_s = S_FETCH;
            S_JMP:      next_state_s = S_FETCH;
            S_JSR:      next_state_s = S_JSR_T;
            S_JSR_T:    next_state_s = S_FETCH;
            S_LDR_A:    next_state_s = S_LDR_RD;
            S_LDR_RD:   next_state_s = mem_last_s ? S_LDR_D : S_LDR_RD;
            S_LDR_D:    next_state_s = S_FETCH;
            S_STR_A:    next_state_s = S_STR_M;
            S_STR_M:    next_state_s = S_STR_WR;
            S_STR_WR:   next_state_s = mem_last_s ? S_FETCH : S_STR_WR;
            S_PAUSE1:   next_state_s = Continue ? S_PAUSE2 : S_PAUSE1;
            S_PAUSE2: begin
                if (Continue) begin
                    next_state_s = S_PAUSE2;
                end else begin
                    // In step mode the pause sits between IR load and decode.
                    next_state_s = STEP_MODE ? S_DECODE : S_FETCH;
                end
            end
            default:    next_state_s = S_HALTED;
        endcase
    end

    // Control word decode; everything idles at zero unless the state names it.
    always_comb begin
        LD       = 8'h00;
        GATE     = 4'h0;
        PCMUX    = 2'b00;
        DRMUX    = 1'b0;
        SR1MUX   = 1'b0;
        SR2MUX   = 1'b0;
        ADDR1MUX = 1'b0;
        ADDR2MUX = 2'b00;
        ALUK     = 2'b00;
        Mem_OE   = 1'b0;
        Mem_WE   = 1'b0;
        Halted   = 1'b0;
        case (state_r)
            S_HALTED: Halted = 1'b1;
            S_FETCH: begin
                GATE[G_PC] = 1'b1;
                LD[L_MAR]  = 1'b1;
                LD[L_PC]   = 1'b1;
                PCMUX      = 2'b00;
            end
            S_FETCH_RD, S_LDR_RD: begin
                Mem_OE = 1'b1;
                // Data is captured only on the final cycle of the access.
                if (mem_last_s) begin
                    LD[L_MDR] = 1'b1;
                end else begin
                    LD[L_MDR] = 1'b0;
                end
            end
            S_IR_LD: begin
                GATE[G_MDR] = 1'b1;
                LD[L_IR]    = 1'b1;
            end
            S_DECODE: LD[L_BEN] = 1'b1;
            S_ADD, S_AND, S_NOT: begin
                SR1MUX      = 1'b1;
                DRMUX       = 1'b1;
                SR2MUX      = IR_5;
                ALUK        = (state_r == S_ADD) ? 2'b00 :
                              (state_r == S_AND) ? 2'b01 : 2'b10;
                GATE[G_ALU] = 1'b1;
                LD[L_REG]   = 1'b1;
                LD[L_CC]    = 1'b1;
            end
            S_BR_T: begin
                ADDR1MUX = 1'b0;
                ADDR2MUX = 2'b10;
                PCMUX    = 2'b10;
                LD[L_PC] = 1'b1;
            end
            S_JMP: begin
                ADDR1MUX = 1'b1;
                ADDR2MUX = 2'b00;
                PCMUX    = 2'b10;
                LD[L_PC] = 1'b1;
            end
            S_JSR: begin
                GATE[G_PC] = 1'b1;
                DRMUX      = 1'b0;
                LD[L_REG]  = 1'b1;
            end
            S_JSR_T: begin
                PCMUX    = 2'b10;
                LD[L_PC] = 1'b1;
                // IR_11 picks PC-relative JSR versus register-based JSRR.
                if (IR_11) begin
                    ADDR1MUX = 1'b0;
                    ADDR2MUX = 2'b11;
                end else begin
                    ADDR1MUX = 1'b1;
                    ADDR2MUX = 2'b00;
                end
            end
            S_LDR_A, S_STR_A: begin
                ADDR1MUX       = 1'b1;
                ADDR2MUX       = 2'b01;
                GATE[G_MARMUX] = 1'b1;
                LD[L_MAR]      = 1'b1;
            end
            S_LDR_D: begin
                GATE[G_MDR] = 1'b1;
                DRMUX       = 1'b1;
                LD[L_REG]   = 1'b1;
                LD[L_CC]    = 1'b1;
            end
            S_STR_M: begin
                SR1MUX      = 1'b1;
                ALUK        = 2'b11;
                GATE[G_ALU] = 1'b1;
                LD[L_MDR]   = 1'b1;
            end
            S_STR_WR: Mem_WE = 1'b1;
            S_PAUSE1: LD[L_LED] = 1'b1;
            default: begin
                LD = 8'h00;
            end
        endcase
    end

endmodule
